// File: rtl/time_ranker_pkg.sv
// Shared definitions for the time ranker: time width, board depth,
// board and state encodings, and the placement one-hot helper.
package time_ranker_pkg;

    // Stopwatch time word: packed digit fields, MSB most significant,
    // so an unsigned compare orders times correctly.
    localparam int TIME_W = 39;

    // Entries per board; slot indices are 2 bits wide.
    localparam int DEPTH = 3;

    // Board selector encodings.
    localparam logic BOARD_FAST = 1'b0;
    localparam logic BOARD_SLOW = 1'b1;

    // Placement value meaning "not placed on the board".
    localparam logic [1:0] POS_NONE = 2'd3;

    // Ranking state machine.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_INS  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One-hot placement with bit0 = first place; POS_NONE maps to 000.
    function automatic logic [2:0] pos_onehot(input logic [1:0] pos);
        logic [2:0] oh;
        case (pos)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rank_board.sv
// One sorted top-3 leaderboard. Holds three slots with valid bits,
// shifts and inserts on command, and compares a candidate time against
// one slot per cycle. SLOW selects the ordering: 0 keeps the smallest
// times, 1 keeps the largest.
module rank_board
    import time_ranker_pkg::*;
#(
    parameter logic SLOW = 1'b0
) (
    input  logic              clock,
    input  logic              wipe,
    input  logic              ins_en,
    input  logic [1:0]        pos,
    input  logic [TIME_W-1:0] new_time,
    input  logic [1:0]        cmp_idx,
    output logic              win,
    input  logic [1:0]        rd_slot,
    output logic [TIME_W-1:0] rd_time,
    output logic              rd_hit
);

    logic [TIME_W-1:0] slot [DEPTH];
    logic [DEPTH-1:0]  valid;

    logic [TIME_W-1:0] cmp_time;
    logic              cmp_valid;
    logic              cmp_in_range;

    // Slot storage: wipe empties everything, an insert pushes the lower
    // entries down by one and the entry leaving slot 2 is discarded.
    always_ff @(posedge clock) begin
        if (wipe) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
            valid <= '0;
        end else if (ins_en) begin
            case (pos)
                2'd0: begin
                    slot[2]  <= slot[1];
                    slot[1]  <= slot[0];
                    slot[0]  <= new_time;
                    valid[2] <= valid[1];
                    valid[1] <= valid[0];
                    valid[0] <= 1'b1;
                end
                2'd1: begin
                    slot[2]  <= slot[1];
                    slot[1]  <= new_time;
                    valid[2] <= valid[1];
                    valid[1] <= 1'b1;
                end
                2'd2: begin
                    slot[2]  <= new_time;
                    valid[2] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Select the slot under comparison; index 3 is never a winner.
    always_comb begin
        cmp_time     = '0;
        cmp_valid    = 1'b0;
        cmp_in_range = 1'b1;
        case (cmp_idx)
            2'd0: begin
                cmp_time  = slot[0];
                cmp_valid = valid[0];
            end
            2'd1: begin
                cmp_time  = slot[1];
                cmp_valid = valid[1];
            end
            2'd2: begin
                cmp_time  = slot[2];
                cmp_valid = valid[2];
            end
            default: cmp_in_range = 1'b0;
        endcase
    end

    // Win on an empty slot or a strictly better time; ties keep the
    // older entry ahead.
    always_comb begin
        win = 1'b0;
        if (cmp_in_range) begin
            if (!cmp_valid) begin
                win = 1'b1;
            end else if (SLOW) begin
                win = (new_time > cmp_time);
            end else begin
                win = (new_time < cmp_time);
            end
        end
    end

    // Combinational read; empty slots and slot 3 read as zero / no hit.
    always_comb begin
        rd_time = '0;
        rd_hit  = 1'b0;
        case (rd_slot)
            2'd0: begin
                rd_hit  = valid[0];
                rd_time = valid[0] ? slot[0] : '0;
            end
            2'd1: begin
                rd_hit  = valid[1];
                rd_time = valid[1] ? slot[1] : '0;
            end
            2'd2: begin
                rd_hit  = valid[2];
                rd_time = valid[2] ? slot[2] : '0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/time_ranker.sv
// Top-3 leaderboard ranker for stopwatch times. A FAST board keeps the
// smallest times, a SLOW board the largest. Each accepted record is
// compared slot by slot, inserted if it places, and the placement is
// reported on rank_led and a one-cycle place_pulse. A registered read
// port serves the display mux.
module time_ranker
    import time_ranker_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              rec_valid,
    input  logic [TIME_W-1:0] rec_time,
    input  logic              rec_board,
    input  logic              clear_boards,
    output logic              busy,
    output logic [2:0]        rank_led,
    output logic [2:0]        place_pulse,
    output logic              dropped,
    input  logic              rd_board,
    input  logic [1:0]        rd_slot,
    output logic [TIME_W-1:0] rd_time,
    output logic              rd_hit
);

    state_t            state;
    logic [1:0]        idx;
    logic [1:0]        pos;
    logic [TIME_W-1:0] new_time;
    logic              board_sel;

    logic              wipe;
    logic              ins_fast;
    logic              ins_slow;
    logic              win_fast;
    logic              win_slow;
    logic              win;
    logic [TIME_W-1:0] fast_rd_time;
    logic [TIME_W-1:0] slow_rd_time;
    logic              fast_rd_hit;
    logic              slow_rd_hit;

    // Reset and clear both empty the boards and abort any insertion.
    assign wipe     = reset | clear_boards;
    assign ins_fast = (state == ST_INS) && (board_sel == BOARD_FAST);
    assign ins_slow = (state == ST_INS) && (board_sel == BOARD_SLOW);
    assign win      = (board_sel == BOARD_SLOW) ? win_slow : win_fast;

    rank_board #(
        .SLOW(BOARD_FAST)
    ) u_fast (
        .clock    (clock),
        .wipe     (wipe),
        .ins_en   (ins_fast),
        .pos      (pos),
        .new_time (new_time),
        .cmp_idx  (idx),
        .win      (win_fast),
        .rd_slot  (rd_slot),
        .rd_time  (fast_rd_time),
        .rd_hit   (fast_rd_hit)
    );

    rank_board #(
        .SLOW(BOARD_SLOW)
    ) u_slow (
        .clock    (clock),
        .wipe     (wipe),
        .ins_en   (ins_slow),
        .pos      (pos),
        .new_time (new_time),
        .cmp_idx  (idx),
        .win      (win_slow),
        .rd_slot  (rd_slot),
        .rd_time  (slow_rd_time),
        .rd_hit   (slow_rd_hit)
    );

    // Ranking state machine with registered busy/rank_led/place_pulse.
    // The placement is registered on leaving INS so that rank_led and
    // place_pulse are already visible during the DONE cycle.
    always_ff @(posedge clock) begin
        if (wipe) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            pos         <= POS_NONE;
            new_time    <= '0;
            board_sel   <= BOARD_FAST;
            busy        <= 1'b0;
            rank_led    <= 3'b000;
            place_pulse <= 3'b000;
        end else begin
            place_pulse <= 3'b000;
            case (state)
                ST_IDLE: begin
                    if (rec_valid && (rec_time != '0)) begin
                        new_time  <= rec_time;
                        board_sel <= rec_board;
                        idx       <= 2'd0;
                        pos       <= POS_NONE;
                        rank_led  <= 3'b000;
                        busy      <= 1'b1;
                        state     <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (win) begin
                        pos   <= idx;
                        state <= ST_INS;
                    end else if (idx < 2'd2) begin
                        idx <= idx + 2'd1;
                    end else begin
                        pos   <= POS_NONE;
                        state <= ST_DONE;
                    end
                end
                ST_INS: begin
                    rank_led    <= pos_onehot(pos);
                    place_pulse <= pos_onehot(pos);
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun flag: any record offered outside IDLE is lost.
    // Survives clear_boards, only reset removes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            dropped <= 1'b0;
        end else if (rec_valid && (state != ST_IDLE)) begin
            dropped <= 1'b1;
        end
    end

    // Registered read port; sampling the boards on the same edge as an
    // insert returns the pre-insertion contents.
    always_ff @(posedge clock) begin
        if (wipe) begin
            rd_time <= '0;
            rd_hit  <= 1'b0;
        end else if (rd_board == BOARD_SLOW) begin
            rd_time <= slow_rd_time;
            rd_hit  <= slow_rd_hit;
        end else begin
            rd_time <= fast_rd_time;
            rd_hit  <= fast_rd_hit;
        end
    end

endmodule

// File: tb/tb_time_ranker.sv
// Directed bench for time_ranker: a table of records with hand-computed
// placements, plus hand-written sequences for drop, clear, reset abort
// and read-during-insert.
module tb_time_ranker;
    import time_ranker_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              rec_valid;
    logic [TIME_W-1:0] rec_time;
    logic              rec_board;
    logic              clear_boards;
    logic              busy;
    logic [2:0]        rank_led;
    logic [2:0]        place_pulse;
    logic              dropped;
    logic              rd_board;
    logic [1:0]        rd_slot;
    logic [TIME_W-1:0] rd_time;
    logic              rd_hit;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic              board;
        logic [TIME_W-1:0] t;
        logic [2:0]        led;
        logic [2:0]        pulse;
    } rec_vec_t;

    rec_vec_t vecs[8];

    always #5 clock = ~clock;

    time_ranker dut (
        .clock        (clock),
        .reset        (reset),
        .rec_valid    (rec_valid),
        .rec_time     (rec_time),
        .rec_board    (rec_board),
        .clear_boards (clear_boards),
        .busy         (busy),
        .rank_led     (rank_led),
        .place_pulse  (place_pulse),
        .dropped      (dropped),
        .rd_board     (rd_board),
        .rd_slot      (rd_slot),
        .rd_time      (rd_time),
        .rd_hit       (rd_hit)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic read_chk(input logic b, input logic [1:0] s, input logic [TIME_W-1:0] t,
                            input logic h, input string name);
        rd_board = b;
        rd_slot  = s;
        tick();
        chk({name, "_time"}, 64'(rd_time), 64'(t));
        chk({name, "_hit"}, 64'(rd_hit), 64'(h));
    endtask

    // Offer one record and follow it until busy falls, collecting pulses.
    task automatic do_record(input logic b, input logic [TIME_W-1:0] t, input logic [2:0] led,
                             input logic [2:0] pulse, input string name);
        logic [2:0] seen;
        int         pcyc;
        bit         done;
        rec_valid = 1'b1;
        rec_time  = t;
        rec_board = b;
        tick();
        rec_valid = 1'b0;
        seen = 3'b000;
        pcyc = 0;
        done = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (place_pulse != 3'b000) begin
                seen |= place_pulse;
                pcyc++;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_led"}, 64'(rank_led), 64'(led));
        chk({name, "_pulse"}, 64'(seen), 64'(pulse));
        chk({name, "_pulse_cycles"}, 64'(pcyc), (pulse != 3'b000) ? 64'd1 : 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seen;

        // FAST board sequence, then SLOW board sequence with a tie.
        vecs[0] = '{BOARD_FAST, 39'd500, 3'b001, 3'b001};
        vecs[1] = '{BOARD_FAST, 39'd300, 3'b001, 3'b001};
        vecs[2] = '{BOARD_FAST, 39'd400, 3'b010, 3'b010};
        vecs[3] = '{BOARD_FAST, 39'd600, 3'b000, 3'b000};
        vecs[4] = '{BOARD_SLOW, 39'd100, 3'b001, 3'b001};
        vecs[5] = '{BOARD_SLOW, 39'd200, 3'b001, 3'b001};
        vecs[6] = '{BOARD_SLOW, 39'd200, 3'b010, 3'b010};
        vecs[7] = '{BOARD_SLOW, 39'd50,  3'b000, 3'b000};

        reset        = 1'b1;
        rec_valid    = 1'b0;
        rec_time     = '0;
        rec_board    = 1'b0;
        clear_boards = 1'b0;
        rd_board     = 1'b0;
        rd_slot      = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_led", 64'(rank_led), 64'd0);
        chk("rst_pulse", 64'(place_pulse), 64'd0);
        chk("rst_dropped", 64'(dropped), 64'd0);
        chk("rst_rd_time", 64'(rd_time), 64'd0);
        chk("rst_rd_hit", 64'(rd_hit), 64'd0);

        // Scenario 1: FAST records.
        for (int i = 0; i < 4; i++) begin
            do_record(vecs[i].board, vecs[i].t, vecs[i].led, vecs[i].pulse, $sformatf("s1_rec%0d", i));
        end
        read_chk(BOARD_FAST, 2'd0, 39'd300, 1'b1, "s1_fast0");
        read_chk(BOARD_FAST, 2'd1, 39'd400, 1'b1, "s1_fast1");
        read_chk(BOARD_FAST, 2'd2, 39'd500, 1'b1, "s1_fast2");

        // Scenario 5: read port basics.
        read_chk(BOARD_FAST, 2'd1, 39'd400, 1'b1, "s5_fast1");
        read_chk(BOARD_FAST, 2'd3, 39'd0, 1'b0, "s5_slot3");
        read_chk(BOARD_SLOW, 2'd0, 39'd0, 1'b0, "s5_slow_empty");

        // Scenario 2: SLOW records, FAST untouched.
        for (int i = 4; i < 8; i++) begin
            do_record(vecs[i].board, vecs[i].t, vecs[i].led, vecs[i].pulse, $sformatf("s2_rec%0d", i));
        end
        read_chk(BOARD_SLOW, 2'd0, 39'd200, 1'b1, "s2_slow0");
        read_chk(BOARD_SLOW, 2'd1, 39'd200, 1'b1, "s2_slow1");
        read_chk(BOARD_SLOW, 2'd2, 39'd100, 1'b1, "s2_slow2");
        read_chk(BOARD_FAST, 2'd0, 39'd300, 1'b1, "s2_fast0");
        read_chk(BOARD_FAST, 2'd2, 39'd500, 1'b1, "s2_fast2");

        // Scenario 3: record 150 on SLOW, offer 700 while busy.
        rec_valid = 1'b1;
        rec_time  = 39'd150;
        rec_board = BOARD_SLOW;
        tick();
        chk("s3_busy_after_accept", 64'(busy), 64'd1);
        rec_time = 39'd700;
        tick();
        rec_valid = 1'b0;
        chk("s3_dropped", 64'(dropped), 64'd1);
        for (int n = 0; n < 10 && busy; n++) tick();
        chk("s3_idle", 64'(busy), 64'd0);
        chk("s3_led", 64'(rank_led), 64'b100);
        read_chk(BOARD_SLOW, 2'd0, 39'd200, 1'b1, "s3_slow0");
        read_chk(BOARD_SLOW, 2'd1, 39'd200, 1'b1, "s3_slow1");
        read_chk(BOARD_SLOW, 2'd2, 39'd150, 1'b1, "s3_slow2");
        read_chk(BOARD_FAST, 2'd0, 39'd300, 1'b1, "s3_fast0");
        read_chk(BOARD_FAST, 2'd1, 39'd400, 1'b1, "s3_fast1");
        read_chk(BOARD_FAST, 2'd2, 39'd500, 1'b1, "s3_fast2");

        // Zero time is ignored: no busy, rank_led kept.
        rec_valid = 1'b1;
        rec_time  = '0;
        rec_board = BOARD_FAST;
        tick();
        rec_valid = 1'b0;
        chk("s3_zero_busy", 64'(busy), 64'd0);
        chk("s3_zero_led", 64'(rank_led), 64'b100);
        tick();
        chk("s3_zero_busy2", 64'(busy), 64'd0);
        read_chk(BOARD_FAST, 2'd0, 39'd300, 1'b1, "s3_zero_fast0");

        // Scenario 6: clear keeps dropped, empties both boards.
        clear_boards = 1'b1;
        tick();
        clear_boards = 1'b0;
        chk("s6_dropped", 64'(dropped), 64'd1);
        chk("s6_led", 64'(rank_led), 64'd0);
        chk("s6_busy", 64'(busy), 64'd0);
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 3; s++) begin
                read_chk(b[0], s[1:0], 39'd0, 1'b0, $sformatf("s6_clr_b%0d_s%0d", b, s));
            end
        end

        // Record 900: CMP, INS (read slot0 here), DONE.
        rec_valid = 1'b1;
        rec_time  = 39'd900;
        rec_board = BOARD_FAST;
        tick();
        rec_valid = 1'b0;
        tick();
        rd_board = BOARD_FAST;
        rd_slot  = 2'd0;
        tick();
        chk("s6_ins_read_time", 64'(rd_time), 64'd0);
        chk("s6_ins_read_hit", 64'(rd_hit), 64'd0);
        chk("s6_led_3cyc", 64'(rank_led), 64'b001);
        chk("s6_pulse", 64'(place_pulse), 64'b001);
        tick();
        chk("s6_busy_low", 64'(busy), 64'd0);
        chk("s6_pulse_gone", 64'(place_pulse), 64'd0);
        read_chk(BOARD_FAST, 2'd0, 39'd900, 1'b1, "s6_fast0");

        // Scenario 4: reset in the CMP cycle of the 4th FAST record.
        do_record(BOARD_FAST, 39'd800, 3'b001, 3'b001, "s4_rec800");
        do_record(BOARD_FAST, 39'd700, 3'b001, 3'b001, "s4_rec700");
        rec_valid = 1'b1;
        rec_time  = 39'd600;
        rec_board = BOARD_FAST;
        tick();
        rec_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("s4_busy", 64'(busy), 64'd0);
        chk("s4_led", 64'(rank_led), 64'd0);
        chk("s4_dropped", 64'(dropped), 64'd0);
        seen = place_pulse;
        for (int n = 0; n < 5; n++) begin
            tick();
            seen |= place_pulse;
        end
        chk("s4_no_pulse", 64'(seen), 64'd0);
        read_chk(BOARD_FAST, 2'd0, 39'd0, 1'b0, "s4_fast0");
        read_chk(BOARD_FAST, 2'd1, 39'd0, 1'b0, "s4_fast1");
        read_chk(BOARD_FAST, 2'd2, 39'd0, 1'b0, "s4_fast2");
        read_chk(BOARD_SLOW, 2'd0, 39'd0, 1'b0, "s4_slow0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
